wdt_hb_seq: RTL and testbench

WDT_HB_SEQ -- requirements
Module: wdt_hb_seq

---
 rtl/wdt_pkg.sv | 18 +
 rtl/wdt_hb_collect.sv | 33 +++
 rtl/wdt_hb_seq.sv | 127 ++++++++++++
 tb/tb_wdt_hb_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared watchdog register map, key values and heartbeat-sequencer FSM states.
package wdt_pkg;

    localparam logic [1:0]  WDT_ADDR_CTRL   = 2'b00;
    localparam logic [1:0]  WDT_ADDR_STATUS = 2'b01;
    localparam logic [1:0]  WDT_ADDR_RELOAD = 2'b10;
    localparam logic [1:0]  WDT_ADDR_KEY    = 2'b11;
    localparam logic [15:0] WDT_KEY_KICK    = 16'hA5A5;
    localparam logic [15:0] WDT_KEY_STOP    = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_BOOT_RLD = 2'd0,
        ST_BOOT_CTL = 2'd1,
        ST_IDLE     = 2'd2,
        ST_KICK     = 2'd3
    } wdt_state_t;

endpackage

// File: rtl/wdt_hb_collect.sv
// Sticky per-requester heartbeat record and round-complete detection.
module wdt_hb_collect #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [NREQ-1:0] hb,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] seen,
    output logic            complete
);

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_seen
            // A heartbeat landing in the clear cycle survives into the next round.
            always_ff @(posedge clk) begin
                if (rst) begin
                    seen[gi] <= 1'b0;
                end else if (!mask[gi]) begin
                    seen[gi] <= 1'b0;
                end else if (en) begin
                    seen[gi] <= (seen[gi] & ~clr) | hb[gi];
                end
            end
        end
    endgenerate

    assign complete = (|mask) && (&(seen | ~mask));

endmodule

// File: rtl/wdt_hb_seq.sv
// Watchdog boot configurator and heartbeat-driven kicker sharing the watchdog MMIO port with a CPU.
// Optional status outputs o_seen/o_kick_cnt are enabled by defining WDT_HB_STATUS_EN.
module wdt_hb_seq
    import wdt_pkg::*;
#(
    parameter int          NREQ        = 4,
    parameter logic [15:0] BOOT_RELOAD = 16'h0100,
    parameter logic [2:0]  BOOT_CTRL   = 3'b011
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_sel,
    input  logic            i_we,
    input  logic            i_re,
    input  logic [1:0]      i_addr,
    input  logic [15:0]     i_wdata,
    output logic [15:0]     o_rdata,
    output logic            o_rdy,
    input  logic [NREQ-1:0] i_hb,
    input  logic [NREQ-1:0] i_hb_mask,
    output logic            o_wdt_sel,
    output logic            o_wdt_we,
    output logic            o_wdt_re,
    output logic [1:0]      o_wdt_addr,
    output logic [15:0]     o_wdt_wdata,
    input  logic [15:0]     i_wdt_rdata,
    input  logic            i_wdt_rdy,
    output logic            o_boot_done
`ifdef WDT_HB_STATUS_EN
    ,
    output logic [NREQ-1:0] o_seen,
    output logic [7:0]      o_kick_cnt
`endif
);

    wdt_state_t      state_reg;
    logic [NREQ-1:0] seen;
    logic            complete;
    logic            collect_en;
    logic            kick_clr;

    assign collect_en = (state_reg == ST_IDLE) || (state_reg == ST_KICK);
    assign kick_clr   = (state_reg == ST_KICK);

    wdt_hb_collect #(.NREQ(NREQ)) u_collect (
        .clk      (i_clk),
        .rst      (i_rst),
        .en       (collect_en),
        .clr      (kick_clr),
        .hb       (i_hb),
        .mask     (i_hb_mask),
        .seen     (seen),
        .complete (complete)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_BOOT_RLD;
            o_boot_done <= 1'b0;
        end else begin
            case (state_reg)
                ST_BOOT_RLD: state_reg <= ST_BOOT_CTL;
                ST_BOOT_CTL: begin
                    state_reg   <= ST_IDLE;
                    o_boot_done <= 1'b1;
                end
                ST_IDLE:     if (complete) state_reg <= ST_KICK;
                default:     state_reg <= ST_IDLE;
            endcase
        end
    end

    // Controller cycles own the port and stall the CPU; IDLE is a pure pass-through.
    always_comb begin
        o_wdt_sel   = 1'b0;
        o_wdt_we    = 1'b0;
        o_wdt_re    = 1'b0;
        o_wdt_addr  = 2'b00;
        o_wdt_wdata = 16'h0000;
        o_rdata     = 16'h0000;
        o_rdy       = 1'b0;
        if (!i_rst) begin
            case (state_reg)
                ST_BOOT_RLD: begin
                    o_wdt_sel   = 1'b1;
                    o_wdt_we    = 1'b1;
                    o_wdt_addr  = WDT_ADDR_RELOAD;
                    o_wdt_wdata = BOOT_RELOAD;
                end
                ST_BOOT_CTL: begin
                    o_wdt_sel   = 1'b1;
                    o_wdt_we    = 1'b1;
                    o_wdt_addr  = WDT_ADDR_CTRL;
                    o_wdt_wdata = {13'b0, BOOT_CTRL};
                end
                ST_KICK: begin
                    o_wdt_sel   = 1'b1;
                    o_wdt_we    = 1'b1;
                    o_wdt_addr  = WDT_ADDR_KEY;
                    o_wdt_wdata = WDT_KEY_KICK;
                end
                default: begin
                    o_wdt_sel   = i_sel;
                    o_wdt_we    = i_sel & i_we;
                    o_wdt_re    = i_sel & i_re;
                    o_wdt_addr  = i_sel ? i_addr : 2'b00;
                    o_wdt_wdata = i_sel ? i_wdata : 16'h0000;
                    o_rdata     = i_wdt_rdata;
                    o_rdy       = i_wdt_rdy;
                end
            endcase
        end
    end

`ifdef WDT_HB_STATUS_EN
    assign o_seen = seen;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_kick_cnt <= 8'h00;
        end else if (state_reg == ST_KICK && o_kick_cnt != 8'hFF) begin
            o_kick_cnt <= o_kick_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_wdt_hb_seq.sv
// Self-checking bench for wdt_hb_seq: directed scenarios plus random traffic against a cycle model.
module tb_wdt_hb_seq;

    localparam int          NREQ        = 4;
    localparam logic [15:0] BOOT_RELOAD = 16'h0100;
    localparam logic [2:0]  BOOT_CTRL   = 3'b011;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_sel, i_we, i_re;
    logic [1:0]      i_addr;
    logic [15:0]     i_wdata;
    logic [15:0]     o_rdata;
    logic            o_rdy;
    logic [NREQ-1:0] i_hb, i_hb_mask;
    logic            o_wdt_sel, o_wdt_we, o_wdt_re;
    logic [1:0]      o_wdt_addr;
    logic [15:0]     o_wdt_wdata;
    logic [15:0]     i_wdt_rdata;
    logic            i_wdt_rdy;
    logic            o_boot_done;
`ifdef WDT_HB_STATUS_EN
    logic [NREQ-1:0] o_seen;
    logic [7:0]      o_kick_cnt;
`endif

    always #5 clk = ~clk;

    wdt_hb_seq #(.NREQ(NREQ), .BOOT_RELOAD(BOOT_RELOAD), .BOOT_CTRL(BOOT_CTRL)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sel       (i_sel),
        .i_we        (i_we),
        .i_re        (i_re),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_rdy       (o_rdy),
        .i_hb        (i_hb),
        .i_hb_mask   (i_hb_mask),
        .o_wdt_sel   (o_wdt_sel),
        .o_wdt_we    (o_wdt_we),
        .o_wdt_re    (o_wdt_re),
        .o_wdt_addr  (o_wdt_addr),
        .o_wdt_wdata (o_wdt_wdata),
        .i_wdt_rdata (i_wdt_rdata),
        .i_wdt_rdy   (i_wdt_rdy),
        .o_boot_done (o_boot_done)
`ifdef WDT_HB_STATUS_EN
        ,
        .o_seen      (o_seen),
        .o_kick_cnt  (o_kick_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int obs_kicks = 0;

    // Reference model: boot phase counter, per-requester seen flags, pending kick, counters.
    int phase = 0;
    bit seen_m[NREQ];
    bit kick_now = 0;
    bit boot_done_m = 0;
    int kick_cnt_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        i_sel = 0; i_we = 0; i_re = 0; i_addr = 0; i_wdata = 0;
    endtask

    task automatic step(input string tag);
        logic        e_sel, e_we, e_re, e_rdy, pass;
        logic [1:0]  e_addr;
        logic [15:0] e_wdata;
        logic [63:0] exp_v, obs_v;
        bit          complete, nk;
        i_wdt_rdata = 16'($urandom);
        #1;
        pass = 0;
        e_sel = 0; e_we = 0; e_re = 0; e_addr = 0; e_wdata = 0; e_rdy = 0;
        if (rst) begin
            // all idle
        end else if (phase == 0) begin
            e_sel = 1; e_we = 1; e_addr = 2'd2; e_wdata = BOOT_RELOAD;
        end else if (phase == 1) begin
            e_sel = 1; e_we = 1; e_addr = 2'd0; e_wdata = {13'b0, BOOT_CTRL};
        end else if (kick_now) begin
            e_sel = 1; e_we = 1; e_addr = 2'd3; e_wdata = 16'hA5A5;
        end else begin
            pass = 1;
            e_sel = i_sel; e_we = i_we; e_re = i_re; e_addr = i_addr; e_wdata = i_wdata;
            e_rdy = i_wdt_rdy;
        end
        exp_v = {41'b0, e_sel, e_we, e_re, e_addr, e_wdata, e_rdy, boot_done_m};
        obs_v = {41'b0, o_wdt_sel, o_wdt_we, o_wdt_re, o_wdt_addr, o_wdt_wdata, o_rdy, o_boot_done};
        check(tag, obs_v, exp_v);
        if (pass) check({tag, "_rdata"}, {48'b0, o_rdata}, {48'b0, i_wdt_rdata});
        if (o_wdt_sel && o_wdt_we && o_wdt_addr == 2'd3 && o_wdt_wdata == 16'hA5A5 &&
            !(i_sel && i_we && i_addr == 2'd3 && i_wdata == 16'hA5A5))
            obs_kicks++;
`ifdef WDT_HB_STATUS_EN
        begin
            logic [NREQ-1:0] es;
            for (int i = 0; i < NREQ; i++) es[i] = seen_m[i];
            check({tag, "_seen"}, {60'b0, o_seen}, {60'b0, es});
            check({tag, "_kcnt"}, {56'b0, o_kick_cnt}, 64'(kick_cnt_m));
        end
`endif
        @(posedge clk);
        if (rst) begin
            phase = 0; kick_now = 0; boot_done_m = 0; kick_cnt_m = 0;
            for (int i = 0; i < NREQ; i++) seen_m[i] = 0;
        end else begin
            complete = (i_hb_mask != 0);
            for (int i = 0; i < NREQ; i++) if (i_hb_mask[i] && !seen_m[i]) complete = 0;
            nk = (phase >= 2) && !kick_now && complete;
            if (phase == 1) boot_done_m = 1;
            if (kick_now && kick_cnt_m < 255) kick_cnt_m++;
            for (int i = 0; i < NREQ; i++) begin
                if (!i_hb_mask[i]) seen_m[i] = 0;
                else if (phase >= 2) seen_m[i] = (kick_now ? 1'b0 : seen_m[i]) | i_hb[i];
            end
            kick_now = nk;
            if (phase < 2) phase++;
        end
        @(negedge clk);
    endtask

    initial begin
        int k0;
        rst = 1; cpu_idle(); i_hb = 0; i_hb_mask = 0; i_wdt_rdy = 1; i_wdt_rdata = 0;
        for (int i = 0; i < NREQ; i++) seen_m[i] = 0;
        @(posedge clk); @(negedge clk);
        step("rst0"); step("rst1");

        // Boot sequence with a CPU read attempting to get in.
        rst = 0; i_sel = 1; i_re = 1; i_addr = 2'd1;
        step("boot_rld"); step("boot_ctl"); step("boot_done");
        cpu_idle(); step("idle");

        // All four requesters on separate cycles.
        k0 = obs_kicks; i_hb_mask = 4'hF;
        for (int b = 0; b < 4; b++) begin i_hb = 4'(1 << b); step("hb_all"); end
        i_hb = 0; step("kick_wait"); step("kick_cyc"); step("post_kick"); step("post_kick2");
        check("kick_once_all", 64'(obs_kicks - k0), 64'd1);

        // Partial mask completes; unmasked bits alone do not.
        k0 = obs_kicks; i_hb_mask = 4'b0101;
        i_hb = 4'b0001; step("m5_a"); i_hb = 0; step("m5_b"); i_hb = 4'b0100; step("m5_c");
        i_hb = 0; step("m5_d"); step("m5_e"); step("m5_f");
        check("kick_once_m5", 64'(obs_kicks - k0), 64'd1);
        k0 = obs_kicks;
        i_hb = 4'b1010; step("m5_unmasked"); i_hb = 0; step("m5_g"); step("m5_h");
        check("no_kick_unmasked", 64'(obs_kicks - k0), 64'd0);
        k0 = obs_kicks; i_hb_mask = 4'b0000;
        for (int j = 0; j < 8; j++) begin i_hb = 4'($urandom); step("mask0"); end
        i_hb = 0; step("mask0_end");
        check("no_kick_mask0", 64'(obs_kicks - k0), 64'd0);

        // Heartbeat and CPU read landing in the kick cycle.
        i_hb_mask = 4'hF;
        i_hb = 4'b0001; step("r_a"); i_hb = 4'b0010; step("r_b");
        i_hb = 4'b1000; step("r_c"); i_hb = 4'b0100; step("r_d");
        i_hb = 0; step("r_idle");
        i_hb = 4'b0100; i_sel = 1; i_re = 1; i_addr = 2'd2; step("r_kick_stall");
        i_hb = 0; step("r_retry");
        cpu_idle(); step("r_after");

        // Reset asserted in the kick cycle restarts boot.
        i_hb = 4'b1011; step("x_a"); i_hb = 0; step("x_idle");
        rst = 1; step("x_rst_in_kick"); step("x_rst_hold");
        rst = 0; step("x_boot_rld"); step("x_boot_ctl"); step("x_idle2");

        // Randomized traffic, including CPU KEY writes and occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) i_hb_mask = 4'($urandom);
            i_hb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            i_wdt_rdy = ($urandom_range(0, 3) != 0);
            cpu_idle();
            if ($urandom_range(0, 2) == 0) begin
                i_sel = 1;
                i_we = $urandom_range(0, 1);
                i_re = ~i_we;
                i_addr = 2'($urandom);
                i_wdata = ($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom);
            end
            step("rand");
        end

        // Many rounds to push the kick counter into saturation.
        rst = 0; cpu_idle(); i_wdt_rdy = 1; i_hb = 0; i_hb_mask = 4'b0001;
        step("sat_pre0"); step("sat_pre1"); step("sat_pre2");
        k0 = obs_kicks;
        for (int r = 0; r < 300; r++) begin
            i_hb = 4'b0001; step("sat_hb"); i_hb = 0; step("sat_idle"); step("sat_kick");
        end
        check("sat_kicks", 64'(obs_kicks - k0), 64'd300);
`ifdef WDT_HB_STATUS_EN
        check("kick_cnt_sat", {56'b0, o_kick_cnt}, 64'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
